// File: rtl/backplane_bus_scheduler_pkg.sv
// Shared definitions for backplane bus sharing: word width, dwell defaults,
// driver timing constants, scheduler FSM encoding and a one-hot helper.
package backplane_pkg;

  localparam int STATE_W           = 7;
  localparam int DRV_SETTLE_CYCLES = 8;
  localparam int DRV_ENABLE_CYCLES = 32;
  localparam int DWELL_CYCLES_DEF  = 48;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    DONE  = 2'd2
  } schedState_t;

  // Supports up to 8 requesters; callers truncate to their own width.
  function automatic logic [7:0] onehot(input logic [2:0] idx);
    onehot = 8'd1 << idx;
  endfunction

endpackage

// File: rtl/backplane_bus_scheduler_rr_arbiter.sv
// Combinational round-robin search: first set request at or above ptr,
// wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               valid
);

  // Walk offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NUM_REQ]) begin
        valid  = 1'b1;
        winner = IDX_W'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/backplane_bus_scheduler.sv
// Round-robin owner of the backplane state bus: latches the winner's word,
// holds it for a dwell window until the driver's enable pulse has ended, then acks.
module backplane_bus_scheduler
  import backplane_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int STATE_W      = backplane_pkg::STATE_W,
  parameter int DWELL_CYCLES = backplane_pkg::DWELL_CYCLES_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*STATE_W-1:0] req_state,
  input  logic                       drv_enable,
  output logic [STATE_W-1:0]         bus_state,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_REQ-1:0]         ack,
  output logic                       busy,
  output logic                       no_enable_err
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [7:0] CNT_LAST = 8'(DWELL_CYCLES - 1);

  schedState_t stateReg, stateNext;
  logic [STATE_W-1:0] busStateReg, busStateNext;
  logic [NUM_REQ-1:0] grantReg, grantNext;
  logic [IDX_W-1:0]   winReg, winNext;
  logic [IDX_W-1:0]   rrPtrReg, rrPtrNext;
  logic [7:0]         cntReg, cntNext;
  logic               seenReg, seenNext;
  logic               errReg, errNext;

  logic [IDX_W-1:0]   arbWinner;
  logic               arbValid;
  logic [STATE_W-1:0] words [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : gUnpack
    assign words[gi] = req_state[gi*STATE_W +: STATE_W];
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) uArb (
    .req    (req),
    .ptr    (rrPtrReg),
    .winner (arbWinner),
    .valid  (arbValid)
  );

  always_comb begin
    stateNext    = stateReg;
    busStateNext = busStateReg;
    grantNext    = grantReg;
    winNext      = winReg;
    rrPtrNext    = rrPtrReg;
    cntNext      = cntReg;
    seenNext     = seenReg;
    errNext      = errReg;
    case (stateReg)
      IDLE: begin
        if (arbValid) begin
          grantNext = NUM_REQ'(onehot(3'(arbWinner)));
          winNext   = arbWinner;
          // A word equal to what the bus already holds produces no driver pulse.
          if (words[arbWinner] != busStateReg) begin
            busStateNext = words[arbWinner];
            cntNext      = '0;
            seenNext     = 1'b0;
            stateNext    = DWELL;
          end else begin
            stateNext = DONE;
          end
        end
      end
      DWELL: begin
        if (cntReg != CNT_LAST) cntNext = cntReg + 8'd1;
        if (drv_enable) seenNext = 1'b1;
        if (cntReg == CNT_LAST && !drv_enable) begin
          stateNext = DONE;
          if (!seenReg) errNext = 1'b1;
        end
      end
      DONE: begin
        grantNext = '0;
        rrPtrNext = (int'(winReg) == NUM_REQ - 1) ? '0 : winReg + IDX_W'(1);
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg    <= IDLE;
      busStateReg <= '0;
      grantReg    <= '0;
      winReg      <= '0;
      rrPtrReg    <= '0;
      cntReg      <= '0;
      seenReg     <= 1'b0;
      errReg      <= 1'b0;
    end else begin
      stateReg    <= stateNext;
      busStateReg <= busStateNext;
      grantReg    <= grantNext;
      winReg      <= winNext;
      rrPtrReg    <= rrPtrNext;
      cntReg      <= cntNext;
      seenReg     <= seenNext;
      errReg      <= errNext;
    end
  end

  assign bus_state     = busStateReg;
  assign grant         = grantReg;
  assign ack           = (stateReg == DONE) ? grantReg : '0;
  assign busy          = (stateReg != IDLE);
  assign no_enable_err = errReg;

endmodule

// File: tb/tb_backplane_bus_scheduler.sv
// Directed plus randomized checks of the bus scheduler against a transaction-level
// model: round-robin winner, dwell exit cycle, word latching and sticky error flag.
module tb_backplane_bus_scheduler;

  localparam int N  = 4;
  localparam int W  = 7;
  localparam int DW = 48;

  logic           clk = 1'b0;
  logic           reset;
  logic           drvEnable;
  logic [N-1:0]   req;
  logic [N*W-1:0] reqState;
  logic [W-1:0]   busState;
  logic [N-1:0]   grant;
  logic [N-1:0]   ack;
  logic           busy;
  logic           noEnableErr;

  int vectors = 0;
  int miscompares = 0;

  int           modelPtr;
  logic [W-1:0] modelBus;
  logic         modelErr;
  logic [W-1:0] words [N];
  logic [N-1:0] pend;
  int           dStart, dLen;
  bit           randDrv, randAbuse;

  backplane_bus_scheduler #(.NUM_REQ(N), .STATE_W(W), .DWELL_CYCLES(DW)) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .req_state     (reqState),
    .drv_enable    (drvEnable),
    .bus_state     (busState),
    .grant         (grant),
    .ack           (ack),
    .busy          (busy),
    .no_enable_err (noEnableErr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pickWinner();
    for (int k = 0; k < N; k++)
      if (pend[(modelPtr + k) % N]) return (modelPtr + k) % N;
    return 0;
  endfunction

  task automatic request(input int i, input logic [W-1:0] wd);
    words[i] = wd;
    pend[i]  = 1'b1;
    req[i]   = 1'b1;
    reqState[i*W +: W] = wd;
  endtask

  // Entered in an IDLE cycle with requests already driven; serves every pending one.
  task automatic serveAll();
    int w, r, expAck, exitC, dS, dE, dL;
    bit same;
    logic errBefore;
    logic [N-1:0] oh;
    while (pend != 0) begin
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_grant", 32'(grant), 32'd0);
      w  = pickWinner();
      oh = N'(1) << w;
      if (randDrv) begin
        dL = $urandom_range(0, 45);
        dS = $urandom_range(1, 40);
      end else begin
        dL = dLen;
        dS = dStart;
      end
      dE = dS + dL - 1;
      same = (words[w] == modelBus);
      errBefore = modelErr;
      exitC = 0;
      if (same) begin
        expAck = 1;
      end else begin
        exitC  = (dL > 0 && dS <= DW && dE >= DW) ? dE + 1 : DW;
        expAck = exitC + 1;
        if (!(dL > 0 && dS <= exitC)) modelErr = 1'b1;
        modelBus = words[w];
      end
      tick();
      r = 1;
      forever begin
        drvEnable = !same && dL > 0 && r >= dS && r <= dE;
        if (randAbuse && !same && r == 3) reqState[w*W +: W] = ~words[w];
        if (randAbuse && !same && r == 4) req[w] = 1'b0;
        check("bus_state", 32'(busState), 32'(modelBus));
        check("grant", 32'(grant), 32'(oh));
        check("busy", 32'(busy), 32'd1);
        check("ack", 32'(ack), (r == expAck) ? 32'(oh) : 32'd0);
        check("no_enable_err", 32'(noEnableErr), (r == expAck) ? 32'(modelErr) : 32'(errBefore));
        if (r >= expAck) break;
        tick();
        r++;
      end
      $display("txn: req%0d word %02h same=%0d drv=[%0d+%0d] ack@t+%0d err=%0d",
               w, words[w], same, dS, dL, expAck, modelErr);
      pend[w]   = 1'b0;
      req[w]    = 1'b0;
      drvEnable = 1'b0;
      modelPtr  = (w + 1) % N;
      tick();
      check("post_ack", 32'(ack), 32'd0);
    end
  endtask

  initial begin
    logic [N-1:0] mask;
    reset = 1'b1; req = '0; reqState = '0; drvEnable = 1'b0;
    pend = '0; modelPtr = 0; modelBus = '0; modelErr = 1'b0;
    randDrv = 1'b0; randAbuse = 1'b0;
    for (int i = 0; i < N; i++) words[i] = '0;
    tick(); tick(); tick();
    check("rst_bus", 32'(busState), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(noEnableErr), 32'd0);
    reset = 1'b0;
    tick();

    dStart = 10; dLen = 32;
    request(0, 7'h15); serveAll();
    request(2, 7'h15); serveAll();
    request(3, 7'h40); serveAll();
    for (int i = 0; i < N; i++) request(i, 7'(i + 1));
    serveAll();
    request(1, 7'h11); serveAll();
    for (int i = 0; i < N; i++) request(i, 7'(8'h21 + i));
    serveAll();

    dStart = 10; dLen = 51;           // enable high through cycle 60
    request(3, 7'h55); serveAll();
    dLen = 0;                         // driver never pulses
    request(1, 7'h7F); serveAll();

    randDrv = 1'b1; randAbuse = 1'b1;
    for (int it = 0; it < 25; it++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++)
        if (mask[i]) request(i, ($urandom_range(0, 3) == 0) ? modelBus : W'($urandom));
      serveAll();
    end
    randDrv = 1'b0; randAbuse = 1'b0;
    dStart = 10; dLen = 32;
    request(2, 7'h01); serveAll();

    // Reset during the dwell of 7'h3C at cnt=20.
    request(0, 7'h3C);
    tick();
    for (int r = 1; r <= 21; r++) begin
      drvEnable = (r >= 10);
      if (r == 1) check("abort_bus_load", 32'(busState), 32'h3C);
      check("abort_ack", 32'(ack), 32'd0);
      if (r < 21) tick();
    end
    reset = 1'b1;
    tick();
    check("abort_bus", 32'(busState), 32'd0);
    check("abort_grant", 32'(grant), 32'd0);
    check("abort_ack_rst", 32'(ack), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_err", 32'(noEnableErr), 32'd0);
    reset = 1'b0; req = '0; drvEnable = 1'b0; pend = '0;
    modelPtr = 0; modelBus = '0; modelErr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("abort_no_ack", 32'(ack), 32'd0);
    end
    request(1, 7'h2A); serveAll();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
